ysyx_22040931_ifu: RTL and testbench

- Instruction fetch unit directly upstream of the RV64 decoder.
- Owns the PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Extracts the 32-bit instruction from the 64-bit response and holds it in an output register until the decoder accepts it.
- Handles PC redirects from jump/branch resolution, including discarding in-flight fetches.

---
 rtl/ysyx_22040931_ifu_pkg.sv | 20 ++
 rtl/ysyx_22040931_ifu.sv | 96 +++++++++
 tb/tb_ysyx_22040931_ifu.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040931_ifu_pkg.sv
// ysyx_22040931_ifu_pkg: shared widths, reset PC, FSM encoding and word select for the fetch unit
package ysyx_22040931_ifu_pkg;

    localparam int          IFU_XLEN     = 64;
    localparam int          IFU_INST_W   = 32;
    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    // Pick the 32-bit instruction out of a returned doubleword using pc[2]
    function automatic logic [IFU_INST_W-1:0] word_sel(input logic [63:0] dword, input logic hi);
        return hi ? dword[63:32] : dword[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22040931_ifu.sv
// ysyx_22040931_ifu: single-outstanding instruction fetch with redirect and in-flight drop
module ysyx_22040931_ifu
    import ysyx_22040931_ifu_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_redirect_valid,
    input  logic [XLEN-1:0]       i_redirect_pc,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [XLEN-1:0]       o_imem_req_addr,
    input  logic                  i_imem_resp_valid,
    input  logic [XLEN-1:0]       i_imem_resp_data,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [IFU_INST_W-1:0] o_inst,
    output logic [XLEN-1:0]       o_inst_pc
);

    ifu_state_e            r_state;
    ifu_state_e            w_state_nx;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       w_pc_nx;
    logic                  r_drop;
    logic                  w_drop_nx;
    logic [IFU_INST_W-1:0] r_inst;
    logic [XLEN-1:0]       r_inst_pc;
    logic                  w_inst_ld;
    logic                  w_req_hs;
    logic [XLEN-1:0]       w_redir_pc;

    assign w_req_hs         = (r_state == REQ) && i_imem_req_ready;
    assign w_redir_pc       = i_redirect_pc & ~XLEN'(3);
    assign o_imem_req_valid = (r_state == REQ);
    assign o_inst_valid     = (r_state == HOLD);
    assign o_imem_req_addr  = {r_pc[XLEN-1:3], 3'b000};
    assign o_inst           = r_inst;
    assign o_inst_pc        = r_inst_pc;

    // Next state, next pc and drop tracking; a redirect overrides the pc in every state
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_drop_nx  = r_drop;
        w_inst_ld  = 1'b0;
        case (r_state)
            IDLE: w_state_nx = REQ;
            REQ: begin
                if (w_req_hs) begin
                    w_state_nx = WAIT;
                    w_drop_nx  = i_redirect_valid;
                end
            end
            WAIT: begin
                if (i_imem_resp_valid) begin
                    w_drop_nx  = 1'b0;
                    w_inst_ld  = !r_drop && !i_redirect_valid;
                    w_state_nx = w_inst_ld ? HOLD : REQ;
                end else if (i_redirect_valid) begin
                    w_drop_nx = 1'b1;
                end
            end
            HOLD: begin
                if (i_inst_ready || i_redirect_valid) begin
                    w_state_nx = REQ;
                    w_pc_nx    = r_pc + XLEN'(4);
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (i_redirect_valid) w_pc_nx = w_redir_pc;
    end

    // State, pc, drop flag and held instruction registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_drop  <= w_drop_nx;
            if (w_inst_ld) begin
                r_inst    <= word_sel(i_imem_resp_data, r_pc[2]);
                r_inst_pc <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_ifu.sv
// tb_ysyx_22040931_ifu: directed scenarios plus randomized traffic against a program-order pc model
module tb_ysyx_22040931_ifu;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_redirect_valid;
    logic [63:0] i_redirect_pc;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [63:0] o_imem_req_addr;
    logic        i_imem_resp_valid;
    logic [63:0] i_imem_resp_data;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_pc;
    int          ready_mode;
    int          lat_cfg;
    bit          fixed;
    logic [63:0] fixed_data;
    bit          pend;
    logic [63:0] pend_addr;
    int          cnt;

    ysyx_22040931_ifu dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_resp_valid(i_imem_resp_valid),
        .i_imem_resp_data (i_imem_resp_data),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Memory contents: a fixed doubleword or an address hash with distinct halves
    function automatic logic [63:0] memd(input logic [63:0] a);
        return fixed ? fixed_data : {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0] + a[63:32] + 32'h1357_9BDF};
    endfunction

    // One clock: advance memory model and architectural pc model, check accepted requests and held instructions
    task automatic step();
        logic        hs, redir, cons, rs;
        logic [63:0] a, tgt, d, ea;
        hs    = o_imem_req_valid && i_imem_req_ready;
        a     = o_imem_req_addr;
        redir = i_redirect_valid;
        tgt   = i_redirect_pc;
        cons  = o_inst_valid && i_inst_ready;
        rs    = i_rst;
        @(posedge clk);
        #1;
        i_imem_resp_valid = 1'b0;
        if (rs && hs) begin
            ea = {exp_pc[63:3], 3'b000};
            n_cmp++;
            if (a !== ea) begin
                n_bad++;
                $display("FAIL req_addr: got %h want %h", a, ea);
            end
            pend      = 1'b1;
            pend_addr = a;
            cnt       = lat_cfg > 0 ? lat_cfg : int'($urandom_range(3, 1));
        end
        if (!rs) exp_pc = RPC;
        else if (redir) exp_pc = {tgt[63:2], 2'b00};
        else if (cons) exp_pc = exp_pc + 64'd4;
        if (pend) begin
            if (cnt <= 1) begin
                i_imem_resp_valid = 1'b1;
                i_imem_resp_data  = memd(pend_addr);
                pend              = 1'b0;
            end else begin
                cnt--;
            end
        end
        i_imem_req_ready = ready_mode == 2 ? 1'($urandom) : 1'(ready_mode);
        if (o_inst_valid) begin
            d = memd({exp_pc[63:3], 3'b000});
            n_cmp++;
            if (o_inst_pc !== exp_pc || o_inst !== (exp_pc[2] ? d[63:32] : d[31:0])) begin
                n_bad++;
                $display("FAIL held_inst: got pc=%h inst=%h want pc=%h inst=%h", o_inst_pc, o_inst, exp_pc,
                         exp_pc[2] ? d[63:32] : d[31:0]);
            end
        end
    endtask

    // Step until an instruction is held, bounded
    task automatic wait_hold(input string nm);
        int k;
        k = 0;
        while (!o_inst_valid && k < 50) begin
            step();
            k++;
        end
        n_cmp++;
        if (!o_inst_valid) begin
            n_bad++;
            $display("FAIL %s: timeout inst_valid=%b want 1", nm, o_inst_valid);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0; i_inst_ready = 1'b0;
        i_imem_req_ready = 1'b1; i_imem_resp_valid = 1'b0; i_imem_resp_data = '0;
        ready_mode = 1; lat_cfg = 1; fixed = 1'b1; fixed_data = 64'h00000013_00500093;
        pend = 1'b0; cnt = 0; exp_pc = RPC;
        step();
        step();
        n_cmp++;
        if (o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b0 || o_imem_req_addr !== RPC) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b iv=%b addr=%h want 0 0 %h", o_imem_req_valid, o_inst_valid,
                     o_imem_req_addr, RPC);
        end
        i_rst = 1'b1;
    endtask

    task automatic test_basic();
        n_cmp++;
        if (o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b0 || o_imem_req_addr !== RPC) begin
            n_bad++;
            $display("FAIL first_cycle: got req=%b iv=%b addr=%h want 0 0 %h", o_imem_req_valid, o_inst_valid,
                     o_imem_req_addr, RPC);
        end
        step();
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== RPC) begin
            n_bad++;
            $display("FAIL first_req: got req=%b addr=%h want 1 %h", o_imem_req_valid, o_imem_req_addr, RPC);
        end
        step();
        n_cmp++;
        if (o_inst_valid !== 1'b0 || o_imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_cycle: got iv=%b req=%b want 0 0", o_inst_valid, o_imem_req_valid);
        end
        step();
        n_cmp++;
        if (o_inst_valid !== 1'b1 || o_inst !== 32'h00500093 || o_inst_pc !== RPC) begin
            n_bad++;
            $display("FAIL first_inst: got iv=%b inst=%h pc=%h want 1 00500093 %h", o_inst_valid, o_inst, o_inst_pc,
                     RPC);
        end
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== RPC) begin
            n_bad++;
            $display("FAIL second_req: got req=%b addr=%h want 1 %h", o_imem_req_valid, o_imem_req_addr, RPC);
        end
        wait_hold("second_inst_wait");
        n_cmp++;
        if (o_inst !== 32'h00000013 || o_inst_pc !== RPC + 64'd4) begin
            n_bad++;
            $display("FAIL second_inst: got inst=%h pc=%h want 00000013 %h", o_inst, o_inst_pc, RPC + 64'd4);
        end
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
        fixed = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] si;
        logic [63:0] sp;
        wait_hold("bp_wait");
        si = o_inst;
        sp = o_inst_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (o_inst !== si || o_inst_pc !== sp || o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_stable: got inst=%h pc=%h req=%b iv=%b want %h %h 0 1", o_inst, o_inst_pc,
                         o_imem_req_valid, o_inst_valid, si, sp);
            end
        end
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
        wait_hold("bp_next_wait");
        n_cmp++;
        if (o_inst_pc !== sp + 64'd4) begin
            n_bad++;
            $display("FAIL bp_advance: got pc=%h want %h", o_inst_pc, sp + 64'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit seen_iv, found;
        lat_cfg = 4;
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
        step();
        i_redirect_valid = 1'b1;
        i_redirect_pc = 64'h0000_0000_8000_0100;
        step();
        i_redirect_valid = 1'b0;
        seen_iv = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (o_inst_valid) seen_iv = 1'b1;
            if (o_imem_req_valid) found = 1'b1;
        end
        n_cmp++;
        if (seen_iv || !found || o_imem_req_addr !== 64'h0000_0000_8000_0100) begin
            n_bad++;
            $display("FAIL redir_wait: got stale_iv=%b req_seen=%b addr=%h want 0 1 0000000080000100", seen_iv,
                     found, o_imem_req_addr);
        end
        lat_cfg = 1;
        wait_hold("redir_wait_hold");
        n_cmp++;
        if (o_inst_pc !== 64'h0000_0000_8000_0100) begin
            n_bad++;
            $display("FAIL redir_wait_pc: got %h want 0000000080000100", o_inst_pc);
        end
    endtask

    task automatic test_redirect_hold();
        i_inst_ready = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc = 64'h0000_0000_8000_0040;
        step();
        i_inst_ready = 1'b0;
        i_redirect_valid = 1'b0;
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 64'h0000_0000_8000_0040) begin
            n_bad++;
            $display("FAIL redir_hold_req: got req=%b addr=%h want 1 0000000080000040", o_imem_req_valid,
                     o_imem_req_addr);
        end
        wait_hold("redir_hold_wait");
        n_cmp++;
        if (o_inst_pc !== 64'h0000_0000_8000_0040) begin
            n_bad++;
            $display("FAIL redir_hold_pc: got %h want 0000000080000040", o_inst_pc);
        end
    endtask

    task automatic test_req_stall();
        logic [63:0] sa;
        ready_mode = 0;
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
        sa = o_imem_req_addr;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== sa) begin
                n_bad++;
                $display("FAIL stall_req: got req=%b addr=%h want 1 %h", o_imem_req_valid, o_imem_req_addr, sa);
            end
        end
        i_redirect_valid = 1'b1;
        i_redirect_pc = 64'h0000_0000_8000_0204;
        step();
        i_redirect_valid = 1'b0;
        ready_mode = 1;
        i_imem_req_ready = 1'b1;
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 64'h0000_0000_8000_0200) begin
            n_bad++;
            $display("FAIL stall_redir_addr: got req=%b addr=%h want 1 0000000080000200", o_imem_req_valid,
                     o_imem_req_addr);
        end
        wait_hold("stall_wait");
        n_cmp++;
        if (o_inst_pc !== 64'h0000_0000_8000_0204) begin
            n_bad++;
            $display("FAIL stall_redir_pc: got %h want 0000000080000204", o_inst_pc);
        end
    endtask

    task automatic test_reset_mid();
        lat_cfg = 3;
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
        step();
        i_rst = 1'b0;
        ready_mode = 0;
        step();
        n_cmp++;
        if (o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b0 || o_imem_req_addr !== RPC) begin
            n_bad++;
            $display("FAIL mid_reset_out: got req=%b iv=%b addr=%h want 0 0 %h", o_imem_req_valid, o_inst_valid,
                     o_imem_req_addr, RPC);
        end
        i_rst = 1'b1;
        step();
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== RPC || i_imem_resp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_req: got req=%b addr=%h late_resp=%b want 1 %h 1", o_imem_req_valid,
                     o_imem_req_addr, i_imem_resp_valid, RPC);
        end
        ready_mode = 1;
        lat_cfg = 1;
        wait_hold("mid_reset_wait");
        n_cmp++;
        if (o_inst_pc !== RPC) begin
            n_bad++;
            $display("FAIL mid_reset_pc: got %h want %h", o_inst_pc, RPC);
        end
    endtask

    task automatic test_wrap();
        i_redirect_valid = 1'b1;
        i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        i_redirect_valid = 1'b0;
        wait_hold("wrap_wait");
        n_cmp++;
        if (o_inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_top: got %h want fffffffffffffffc", o_inst_pc);
        end
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
        wait_hold("wrap_zero_wait");
        n_cmp++;
        if (o_inst_pc !== 64'd0) begin
            n_bad++;
            $display("FAIL wrap_zero: got %h want 0", o_inst_pc);
        end
    endtask

    task automatic test_random();
        ready_mode = 2;
        lat_cfg = 0;
        for (int i = 0; i < 600; i++) begin
            i_inst_ready = $urandom_range(0, 2) != 0;
            i_redirect_valid = $urandom_range(0, 7) == 0;
            i_redirect_pc = $urandom_range(0, 1) ? RPC + 64'($urandom_range(0, 1023)) : {$urandom, $urandom};
            step();
        end
        i_inst_ready = 1'b0;
        i_redirect_valid = 1'b0;
        ready_mode = 1;
        lat_cfg = 1;
        wait_hold("random_drain");
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_req_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
